// File: rtl/tick_seq_gen_if.sv
// Signal bundle for tick_seq_gen: fault/restart controls in, timing strobes,
// fanout reset and stage enables out.
interface tick_seq_gen_if #(
  parameter int unsigned NUM_STG = 4
);
  logic               fault_i;
  logic               restart_i;
  logic               rst_o;
  logic               strobe_o;
  logic               slow_tick_o;
  logic               hb_o;
  logic [NUM_STG-1:0] stg_en_o;
  logic               seq_done_o;
  logic               fault_o;

  // Generator side
  modport master (
    input  fault_i, restart_i,
    output rst_o, strobe_o, slow_tick_o, hb_o, stg_en_o, seq_done_o, fault_o
  );

  // Consumer side
  modport slave (
    output fault_i, restart_i,
    input  rst_o, strobe_o, slow_tick_o, hb_o, stg_en_o, seq_done_o, fault_o
  );
endinterface

// File: rtl/tick_seq_gen.sv
// tick_seq_gen: reset synchroniser, base/slow strobe generator, heartbeat and
// a power-enable sequencer that brings stages up one by one.
// Optional feature macro: TICK_SEQ_GEN_FAULT_EN (fault shutdown / restart).
module tick_seq_gen #(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned TICK_HZ  = 400_000,
  parameter int unsigned SLOW_DIV = 400,
  parameter int unsigned NUM_STG  = 4,
  parameter logic [NUM_STG*8-1:0] STG_DLY = {NUM_STG{8'd1}}
) (
  input  logic            clk_100,
  input  logic            srst0,
  tick_seq_gen_if.master  bus
);

  localparam int unsigned CLK_DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned BW      = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned SW      = (SLOW_DIV > 1) ? $clog2(SLOW_DIV) : 1;
  localparam int unsigned KW      = (NUM_STG > 1) ? $clog2(NUM_STG) : 1;

  // Parameter sanity
  generate
    if (CLK_DIV < 2) begin : g_bad_clk_div
      $error("tick_seq_gen: CLK_HZ/TICK_HZ must be at least 2");
    end
    if (SLOW_DIV < 1) begin : g_bad_slow_div
      $error("tick_seq_gen: SLOW_DIV must be at least 1");
    end
    if ((NUM_STG < 1) || (NUM_STG > 16)) begin : g_bad_num_stg
      $error("tick_seq_gen: NUM_STG must be in 1..16");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_UP    = 2'd0,
    ST_DONE  = 2'd1,
    ST_SHDN  = 2'd2,
    ST_FAULT = 2'd3
  } state_t;

  logic [1:0]         rst_sync;
  logic               rst_int;
  logic [BW-1:0]      base_cnt;
  logic [SW-1:0]      slow_cnt;
  logic               base_wrap;
  logic               slow_wrap;
  logic               strobe_q;
  logic               slow_tick_q;
  logic               hb_q;
  state_t             state;
  logic [KW-1:0]      stg_idx;
  logic [7:0]         dly_cnt;
  logic [7:0]         cur_dly;
  logic [NUM_STG-1:0] stg_en_q;
  logic               seq_done_q;
  logic               flt_s;

  // Reset synchroniser: asserts with srst0, releases on the 2nd edge after
  always_ff @(posedge clk_100 or posedge srst0) begin
    if (srst0) rst_sync <= 2'b11;
    else       rst_sync <= {rst_sync[0], 1'b0};
  end

  assign rst_int   = rst_sync[1];
  assign base_wrap = (base_cnt == BW'(CLK_DIV - 1));
  assign slow_wrap = base_wrap && (slow_cnt == SW'(SLOW_DIV - 1));
  assign cur_dly   = STG_DLY[{stg_idx, 3'b000} +: 8];

  // Free-running base/slow dividers and heartbeat
  always_ff @(posedge clk_100 or posedge rst_int) begin
    if (rst_int) begin
      base_cnt    <= '0;
      slow_cnt    <= '0;
      strobe_q    <= 1'b0;
      slow_tick_q <= 1'b0;
      hb_q        <= 1'b0;
    end else begin
      base_cnt    <= base_wrap ? '0 : base_cnt + BW'(1);
      strobe_q    <= base_wrap;
      slow_tick_q <= slow_wrap;
      if (base_wrap) slow_cnt <= slow_wrap ? '0 : slow_cnt + SW'(1);
      if (slow_wrap) hb_q <= ~hb_q;
    end
  end

`ifdef TICK_SEQ_GEN_FAULT_EN
  logic [1:0] flt_sync;
  logic       fault_q;

  // Two-flop synchroniser for the asynchronous fault level
  always_ff @(posedge clk_100 or posedge rst_int) begin
    if (rst_int) flt_sync <= 2'b00;
    else         flt_sync <= {flt_sync[0], bus.fault_i};
  end

  assign flt_s       = flt_sync[1];
  assign bus.fault_o = fault_q;
`else
  logic unused_ctl;

  assign unused_ctl  = bus.fault_i ^ bus.restart_i;
  assign flt_s       = 1'b0;
  assign bus.fault_o = 1'b0;
`endif

  // Sequencer FSM: stage-by-stage power-up, shutdown on fault, restart
  always_ff @(posedge clk_100 or posedge rst_int) begin
    if (rst_int) begin
      state      <= ST_UP;
      stg_idx    <= '0;
      dly_cnt    <= '0;
      stg_en_q   <= '0;
      seq_done_q <= 1'b0;
`ifdef TICK_SEQ_GEN_FAULT_EN
      fault_q    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_UP: begin
          if (flt_s) begin
            state      <= ST_SHDN;
            seq_done_q <= 1'b0;
          end else if (slow_tick_q) begin
            if (dly_cnt == cur_dly) begin
              stg_en_q <= stg_en_q | (NUM_STG'(1) << stg_idx);
              dly_cnt  <= '0;
              if (stg_idx == KW'(NUM_STG - 1)) begin
                state      <= ST_DONE;
                seq_done_q <= 1'b1;
              end else begin
                stg_idx <= stg_idx + KW'(1);
              end
            end else begin
              dly_cnt <= dly_cnt + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (flt_s) begin
            state      <= ST_SHDN;
            seq_done_q <= 1'b0;
          end
        end
`ifdef TICK_SEQ_GEN_FAULT_EN
        ST_SHDN: begin
          // Thermometer code: shifting right drops the highest enabled stage
          if (stg_en_q == '0) begin
            state   <= ST_FAULT;
            fault_q <= 1'b1;
          end else if (slow_tick_q) begin
            stg_en_q <= stg_en_q >> 1;
          end
        end
        ST_FAULT: begin
          if (bus.restart_i && !flt_s) begin
            state   <= ST_UP;
            fault_q <= 1'b0;
            stg_idx <= '0;
            dly_cnt <= '0;
          end
        end
`endif
        default: state <= ST_UP;
      endcase
    end
  end

  assign bus.rst_o       = rst_int;
  assign bus.strobe_o    = strobe_q;
  assign bus.slow_tick_o = slow_tick_q;
  assign bus.hb_o        = hb_q;
  assign bus.stg_en_o    = stg_en_q;
  assign bus.seq_done_o  = seq_done_q;

endmodule

// File: tb/tb_tick_seq_gen.sv
// Bench for tick_seq_gen: strobe/heartbeat timing checked every cycle against
// closed-form expectations, stage-enable events checked against a queue of
// expected (value, cycle) pairs pushed as stimulus is applied.
module tb_tick_seq_gen;

  typedef struct {
    logic [2:0]  stg;
    logic        done;
    logic        flt;
    int unsigned at;
  } exp_t;

  logic        clk_100;
  logic        srst0;
  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned rel;
  bit          started;
  logic [4:0]  prev;
  exp_t        exp_q[$];

  tick_seq_gen_if #(.NUM_STG(3)) bus ();

  tick_seq_gen #(
    .CLK_HZ  (100),
    .TICK_HZ (10),
    .SLOW_DIV(4),
    .NUM_STG (3),
    .STG_DLY ({8'd2, 8'd0, 8'd1})
  ) dut (
    .clk_100(clk_100),
    .srst0  (srst0),
    .bus    (bus)
  );

  initial clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  // Count one comparison, report it if it does not match
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (rel %0d)", tag, got, exp, rel);
    end
  endtask

  task automatic expect_evt(input logic [2:0] s, input logic d, input logic f, input int unsigned at);
    exp_t e;
    e.stg  = s;
    e.done = d;
    e.flt  = f;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  // Advance one cycle, track cycles since reset release, check outputs
  task automatic step();
    logic [4:0] cur;
    exp_t       e;
    @(negedge clk_100);
    if (bus.rst_o === 1'b1) begin
      started = 1'b0;
    end else if (!started) begin
      started = 1'b1;
      rel     = 0;
    end else begin
      rel++;
    end
    cur = {bus.stg_en_o, bus.seq_done_o, bus.fault_o};
    if (started) begin
      check("strobe", 32'(bus.strobe_o), 32'((rel % 10 == 0) && (rel != 0)));
      check("slow_tick", 32'(bus.slow_tick_o), 32'((rel % 40 == 0) && (rel != 0)));
      check("hb", 32'(bus.hb_o), 32'((rel / 40) % 2));
      if (cur !== prev) begin
        if (exp_q.size() == 0) begin
          check("no_change", 32'(cur), 32'(prev));
        end else begin
          e = exp_q.pop_front();
          check("evt_val", 32'(cur), 32'({e.stg, e.done, e.flt}));
          check("evt_at", rel, e.at);
        end
      end
    end
    prev = cur;
  endtask

  task automatic run_to(input int unsigned n);
    int unsigned guard;
    guard = 0;
    while (!(started && rel >= n) && guard < 5000) begin
      step();
      guard++;
    end
    check("run_to", rel, n);
  endtask

  task automatic pulse_restart();
    bus.restart_i = 1'b1;
    step();
    bus.restart_i = 1'b0;
  endtask

  task automatic release_reset();
    srst0 = 1'b0;
    step();
    check("rst_hold", 32'(bus.rst_o), 32'd1);
    step();
    check("rst_rel", 32'(bus.rst_o), 32'd0);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rel           = 0;
    started       = 1'b0;
    prev          = '0;
    srst0         = 1'b1;
    bus.restart_i = 1'b0;
`ifdef TICK_SEQ_GEN_FAULT_EN
    bus.fault_i   = 1'b0;
`else
    bus.fault_i   = 1'b1;
`endif
    repeat (3) step();
    check("rst_rst_o", 32'(bus.rst_o), 32'd1);
    check("rst_strobe", 32'(bus.strobe_o), 32'd0);
    check("rst_slow", 32'(bus.slow_tick_o), 32'd0);
    check("rst_hb", 32'(bus.hb_o), 32'd0);
    check("rst_stg", 32'(bus.stg_en_o), 32'd0);
    check("rst_done", 32'(bus.seq_done_o), 32'd0);
    check("rst_fault", 32'(bus.fault_o), 32'd0);

    // First power-up, interrupted by srst0 while two stages are on
    expect_evt(3'b001, 1'b0, 1'b0, 81);
    expect_evt(3'b011, 1'b0, 1'b0, 121);
    release_reset();
    run_to(130);
    check("pre_srst_stg", 32'(bus.stg_en_o), 32'h3);
    check("q_pre_srst", exp_q.size(), 0);
    #2 srst0 = 1'b1;
    #1;
    check("async_stg", 32'(bus.stg_en_o), 32'd0);
    check("async_rst", 32'(bus.rst_o), 32'd1);
    step();
    step();

    // Full power-up after release
    expect_evt(3'b001, 1'b0, 1'b0, 81);
    expect_evt(3'b011, 1'b0, 1'b0, 121);
    expect_evt(3'b111, 1'b1, 1'b0, 241);
    release_reset();
    run_to(259);
    pulse_restart();

`ifdef TICK_SEQ_GEN_FAULT_EN
    run_to(299);
    bus.fault_i = 1'b1;
    expect_evt(3'b111, 1'b0, 1'b0, 302);
    expect_evt(3'b011, 1'b0, 1'b0, 321);
    expect_evt(3'b001, 1'b0, 1'b0, 361);
    expect_evt(3'b000, 1'b0, 1'b0, 401);
    expect_evt(3'b000, 1'b0, 1'b1, 402);
    run_to(409);
    pulse_restart();
    run_to(419);
    bus.fault_i = 1'b0;
    run_to(429);
    check("fault_held", 32'(bus.fault_o), 32'd1);
    expect_evt(3'b000, 1'b0, 1'b0, 430);
    expect_evt(3'b001, 1'b0, 1'b0, 481);
    expect_evt(3'b011, 1'b0, 1'b0, 521);
    expect_evt(3'b111, 1'b1, 1'b0, 641);
    pulse_restart();
    run_to(700);
    check("end_stg", 32'(bus.stg_en_o), 32'h7);
`else
    run_to(429);
    pulse_restart();
    run_to(500);
    check("fault_tied", 32'(bus.fault_o), 32'd0);
    check("end_stg", 32'(bus.stg_en_o), 32'h7);
    check("end_done", 32'(bus.seq_done_o), 32'd1);
`endif
    check("q_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
